// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the MEM stage: writeback select codes,
// access FSM state encodings, datapath widths and an address helper.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_PC4 = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mau_state_t;

    // Drop the byte offset so the memory always sees a word address.
    function automatic logic [DATA_W-1:0] word_addr(input logic [DATA_W-1:0] a);
        return {a[DATA_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge port. The master issues requests and
// the slave (memory) returns read data together with ack.
interface mem_access_unit_if;

    logic                        req;
    logic                        we;
    logic [pipe_pkg::DATA_W-1:0] addr;
    logic [pipe_pkg::DATA_W-1:0] wdata;
    logic [pipe_pkg::DATA_W-1:0] rdata;
    logic                        ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);

endinterface

// File: rtl/mem_access_unit_mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears the write enable and the
// alignment flag and leaves the remaining fields holding.
module mem_wb_reg
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              bubble,
    input  logic [DATA_W-1:0] wrdata,
    input  logic [REG_W-1:0]  wraddr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] inst,
    input  logic              align,
    output logic [DATA_W-1:0] WB_wrdata,
    output logic [REG_W-1:0]  WB_wraddr,
    output logic              WB_wr_en,
    output logic [DATA_W-1:0] pc_WB,
    output logic [DATA_W-1:0] WB_inst,
    output logic              align_err
);

    // Load the stage each cycle unless the MEM stage is stalled.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            WB_wrdata <= '0;
            WB_wraddr <= '0;
            WB_wr_en  <= 1'b0;
            pc_WB     <= '0;
            WB_inst   <= '0;
            align_err <= 1'b0;
        end else if (bubble) begin
            WB_wr_en  <= 1'b0;
            align_err <= 1'b0;
        end else begin
            WB_wrdata <= wrdata;
            WB_wraddr <= wraddr;
            WB_wr_en  <= wr_en;
            pc_WB     <= pc;
            WB_inst   <= inst;
            align_err <= align;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: drives the data-memory handshake, stalls the
// front of the pipe while a request waits, aborts after TIMEOUT cycles and
// feeds the MEM/WB register. Optional MEM_FWD_EN adds combinational
// MEM-stage forwarding outputs for non-memory results.
module mem_access_unit
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [DATA_W-1:0] MEM_pc4,
    input  logic [DATA_W-1:0] MEM_ALUres,
    input  logic [DATA_W-1:0] MEM_dataB,
    input  logic [REG_W-1:0]  MEM_wraddr,
    input  logic [DATA_W-1:0] pc_MEM,
    input  logic [DATA_W-1:0] MEM_inst,
    input  logic              MEM_data_wr,
    input  logic              MEM_wr_en,
    input  logic [1:0]        MEM_sel_data,
    mem_access_unit_if.master dmem,
    output logic              stall,
    output logic [DATA_W-1:0] WB_wrdata,
    output logic [REG_W-1:0]  WB_wraddr,
    output logic              WB_wr_en,
    output logic [DATA_W-1:0] pc_WB,
    output logic [DATA_W-1:0] WB_inst,
    output logic              align_err,
    output logic              bus_err
`ifdef MEM_FWD_EN
    ,
    output logic              mem_fwd_valid,
    output logic [REG_W-1:0]  mem_fwd_addr,
    output logic [DATA_W-1:0] mem_fwd_data
`endif
);

    mau_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              store, load, access, misaligned;
    logic              req, complete, abort;
    logic [DATA_W-1:0] wb_data;
    logic              wb_wr_en;

    assign store      = MEM_data_wr;
    assign load       = !MEM_data_wr && (MEM_sel_data == SEL_MEM);
    assign access     = store || load;
    assign misaligned = access && (MEM_ALUres[1:0] != 2'b00);

    // Reset gates the request combinationally so it drops the moment nrst falls.
    assign dmem.req   = nrst && req;
    assign dmem.we    = store;
    assign dmem.addr  = word_addr(MEM_ALUres);
    assign dmem.wdata = MEM_dataB;

    assign stall = nrst && access && !misaligned && !complete && !abort;

    // State register for the access FSM.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state plus request/complete/abort decode.
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        complete  = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_IDLE: begin
                req = access && !misaligned;
                if (req && dmem.ack)  complete  = 1'b1;
                else if (req)         state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                req = 1'b1;
                if (dmem.ack) begin
                    complete  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    abort     = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Wait-cycle counter: zero on entry to WAIT, counts while staying there.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)                                         cnt <= '0;
        else if (state == ST_WAIT && state_nxt == ST_WAIT) cnt <= cnt + CNT_W'(1);
        else                                               cnt <= '0;
    end

    // Sticky record that a memory access was abandoned on timeout.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)      bus_err <= 1'b0;
        else if (abort) bus_err <= 1'b1;
    end

    // Writeback data select; load data is taken straight from the ack cycle.
    always_comb begin
        wb_data = MEM_ALUres;
        case (MEM_sel_data)
            SEL_MEM: wb_data = dmem.rdata;
            SEL_PC4: wb_data = MEM_pc4;
            default: wb_data = MEM_ALUres;
        endcase
    end

    // Stores never write a register, even if the decoder says so.
    assign wb_wr_en = MEM_wr_en && !store && !misaligned && !abort;

    mem_wb_reg u_mem_wb (
        .clk       (clk),
        .nrst      (nrst),
        .bubble    (stall),
        .wrdata    (wb_data),
        .wraddr    (MEM_wraddr),
        .wr_en     (wb_wr_en),
        .pc        (pc_MEM),
        .inst      (MEM_inst),
        .align     (misaligned),
        .WB_wrdata (WB_wrdata),
        .WB_wraddr (WB_wraddr),
        .WB_wr_en  (WB_wr_en),
        .pc_WB     (pc_WB),
        .WB_inst   (WB_inst),
        .align_err (align_err)
    );

`ifdef MEM_FWD_EN
    assign mem_fwd_valid = MEM_wr_en && !load && !store;
    assign mem_fwd_addr  = MEM_wraddr;
    assign mem_fwd_data  = (MEM_sel_data == SEL_PC4) ? MEM_pc4 : MEM_ALUres;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: zero-wait and multi-cycle accesses,
// misalignment, timeout, jal writeback, back-to-back issue and reset mid-wait.
module tb_mem_access_unit;
    import pipe_pkg::*;

    logic              clk = 1'b0;
    logic              nrst;
    logic [31:0]       MEM_pc4, MEM_ALUres, MEM_dataB, pc_MEM, MEM_inst;
    logic [4:0]        MEM_wraddr;
    logic              MEM_data_wr, MEM_wr_en;
    logic [1:0]        MEM_sel_data;
    logic              stall, WB_wr_en, align_err, bus_err;
    logic [31:0]       WB_wrdata, pc_WB, WB_inst;
    logic [4:0]        WB_wraddr;
`ifdef MEM_FWD_EN
    logic              mem_fwd_valid;
    logic [4:0]        mem_fwd_addr;
    logic [31:0]       mem_fwd_data;
`endif
    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit_if dmem ();

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .nrst(nrst),
        .MEM_pc4(MEM_pc4), .MEM_ALUres(MEM_ALUres), .MEM_dataB(MEM_dataB),
        .MEM_wraddr(MEM_wraddr), .pc_MEM(pc_MEM), .MEM_inst(MEM_inst),
        .MEM_data_wr(MEM_data_wr), .MEM_wr_en(MEM_wr_en), .MEM_sel_data(MEM_sel_data),
        .dmem(dmem), .stall(stall),
        .WB_wrdata(WB_wrdata), .WB_wraddr(WB_wraddr), .WB_wr_en(WB_wr_en),
        .pc_WB(pc_WB), .WB_inst(WB_inst), .align_err(align_err), .bus_err(bus_err)
`ifdef MEM_FWD_EN
        , .mem_fwd_valid(mem_fwd_valid), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data)
`endif
    );

    task automatic set_nop();
        MEM_pc4 = 32'h0; MEM_ALUres = 32'h0; MEM_dataB = 32'h0; pc_MEM = 32'h0;
        MEM_inst = 32'h0000_0013; MEM_wraddr = 5'd0; MEM_data_wr = 1'b0;
        MEM_wr_en = 1'b0; MEM_sel_data = SEL_ALU; dmem.ack = 1'b0; dmem.rdata = 32'h0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        set_nop();
        MEM_sel_data = SEL_MEM; MEM_ALUres = 32'h80;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (dmem.req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", dmem.req); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall); end
        n_checks++; if ({WB_wrdata, WB_wraddr, WB_wr_en, pc_WB, WB_inst, align_err, bus_err} !== '0) begin
            n_fail++; $display("FAIL rst_outputs: wrdata=%h wraddr=%0d wr_en=%b pc=%h inst=%h ae=%b be=%b want all 0",
                               WB_wrdata, WB_wraddr, WB_wr_en, pc_WB, WB_inst, align_err, bus_err);
        end
        set_nop();
        @(negedge clk); nrst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_wait_load();
        MEM_ALUres = 32'h100; MEM_sel_data = SEL_MEM; MEM_wr_en = 1'b1; MEM_wraddr = 5'd8;
        pc_MEM = 32'h1000; MEM_inst = 32'h1000_0403;
        dmem.ack = 1'b1; dmem.rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zwl_stall: got %b want 0", stall); end
        n_checks++; if (dmem.req !== 1'b1 || dmem.we !== 1'b0 || dmem.addr !== 32'h100) begin
            n_fail++; $display("FAIL zwl_port: req=%b we=%b addr=%h want 1 0 00000100", dmem.req, dmem.we, dmem.addr);
        end
`ifdef MEM_FWD_EN
        n_checks++; if (mem_fwd_valid !== 1'b0) begin n_fail++; $display("FAIL zwl_fwd_valid: got %b want 0", mem_fwd_valid); end
`endif
        @(posedge clk); #1;
        set_nop();
        n_checks++; if (WB_wrdata !== 32'hDEAD_BEEF || WB_wraddr !== 5'd8 || WB_wr_en !== 1'b1) begin
            n_fail++; $display("FAIL zwl_wb: wrdata=%h wraddr=%0d wr_en=%b want deadbeef 8 1", WB_wrdata, WB_wraddr, WB_wr_en);
        end
        n_checks++; if (pc_WB !== 32'h1000 || WB_inst !== 32'h1000_0403) begin
            n_fail++; $display("FAIL zwl_pc_inst: pc=%h inst=%h want 00001000 10000403", pc_WB, WB_inst);
        end
    endtask

    task automatic test_wait_store();
        int stall_cycles = 0;
        MEM_data_wr = 1'b1; MEM_dataB = 32'h1234_5678; MEM_ALUres = 32'h204;
        MEM_wr_en = 1'b1; MEM_wraddr = 5'd10; pc_MEM = 32'h1004; MEM_inst = 32'h0000_2223;
        for (int i = 0; i < 3; i++) begin
            dmem.ack = (i == 2);
            @(negedge clk);
            if (i == 0) begin
                n_checks++; if (dmem.req !== 1'b1 || dmem.we !== 1'b1 || dmem.addr !== 32'h204 || dmem.wdata !== 32'h1234_5678) begin
                    n_fail++; $display("FAIL st_port: req=%b we=%b addr=%h wdata=%h want 1 1 00000204 12345678",
                                       dmem.req, dmem.we, dmem.addr, dmem.wdata);
                end
            end
            n_checks++; if (stall !== (i < 2)) begin n_fail++; $display("FAIL st_stall_c%0d: got %b want %b", i, stall, (i < 2)); end
            if (stall) stall_cycles++;
            @(posedge clk); #1;
            if (i == 0) begin
                n_checks++; if (WB_wr_en !== 1'b0) begin n_fail++; $display("FAIL st_bubble: WB_wr_en=%b want 0", WB_wr_en); end
            end
        end
        set_nop();
        n_checks++; if (stall_cycles != 2) begin n_fail++; $display("FAIL st_stall_count: got %0d want 2", stall_cycles); end
        n_checks++; if (WB_wr_en !== 1'b0 || pc_WB !== 32'h1004) begin
            n_fail++; $display("FAIL st_retire: wr_en=%b pc=%h want 0 00001004", WB_wr_en, pc_WB);
        end
    endtask

    task automatic test_jal();
        MEM_sel_data = SEL_PC4; MEM_pc4 = 32'h40; MEM_ALUres = 32'h99; MEM_wraddr = 5'd31;
        MEM_wr_en = 1'b1; pc_MEM = 32'h3C; MEM_inst = 32'h0000_00EF;
        @(negedge clk);
        n_checks++; if (dmem.req !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL jal_noreq: req=%b stall=%b want 0 0", dmem.req, stall);
        end
`ifdef MEM_FWD_EN
        n_checks++; if (mem_fwd_valid !== 1'b1 || mem_fwd_data !== 32'h40 || mem_fwd_addr !== 5'd31) begin
            n_fail++; $display("FAIL jal_fwd: valid=%b data=%h addr=%0d want 1 00000040 31", mem_fwd_valid, mem_fwd_data, mem_fwd_addr);
        end
`endif
        @(posedge clk); #1;
        set_nop();
        n_checks++; if (WB_wrdata !== 32'h40 || WB_wraddr !== 5'd31 || WB_wr_en !== 1'b1) begin
            n_fail++; $display("FAIL jal_wb: wrdata=%h wraddr=%0d wr_en=%b want 00000040 31 1", WB_wrdata, WB_wraddr, WB_wr_en);
        end
    endtask

    task automatic test_misaligned();
        MEM_ALUres = 32'h102; MEM_sel_data = SEL_MEM; MEM_wr_en = 1'b1; MEM_wraddr = 5'd9;
        pc_MEM = 32'h2000; dmem.ack = 1'b1;
        @(negedge clk);
        n_checks++; if (dmem.req !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL mis_noreq: req=%b stall=%b want 0 0", dmem.req, stall);
        end
        n_checks++; if (dmem.addr !== 32'h100) begin n_fail++; $display("FAIL mis_addr: got %h want 00000100", dmem.addr); end
        @(posedge clk); #1;
        set_nop();
        n_checks++; if (align_err !== 1'b1 || WB_wr_en !== 1'b0 || pc_WB !== 32'h2000) begin
            n_fail++; $display("FAIL mis_retire: align_err=%b wr_en=%b pc=%h want 1 0 00002000", align_err, WB_wr_en, pc_WB);
        end
        @(posedge clk); #1;
        n_checks++; if (align_err !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: align_err=%b want 0", align_err); end
    endtask

    task automatic test_back_to_back();
        MEM_sel_data = SEL_ALU; MEM_ALUres = 32'hA5A5; MEM_wraddr = 5'd3; MEM_wr_en = 1'b1;
        @(posedge clk); #1;
        MEM_sel_data = 2'b11; MEM_ALUres = 32'h5A5A; MEM_wraddr = 5'd4;
        n_checks++; if (WB_wrdata !== 32'hA5A5 || WB_wraddr !== 5'd3 || WB_wr_en !== 1'b1) begin
            n_fail++; $display("FAIL b2b_alu0: wrdata=%h wraddr=%0d wr_en=%b want 0000a5a5 3 1", WB_wrdata, WB_wraddr, WB_wr_en);
        end
        @(posedge clk); #1;
        MEM_sel_data = SEL_MEM; MEM_ALUres = 32'h300; MEM_wraddr = 5'd5;
        dmem.ack = 1'b1; dmem.rdata = 32'hCAFE_0001;
        n_checks++; if (WB_wrdata !== 32'h5A5A || WB_wraddr !== 5'd4) begin
            n_fail++; $display("FAIL b2b_alu3: wrdata=%h wraddr=%0d want 00005a5a 4", WB_wrdata, WB_wraddr);
        end
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: got %b want 0", stall); end
        @(posedge clk); #1;
        set_nop();
        n_checks++; if (WB_wrdata !== 32'hCAFE_0001 || WB_wraddr !== 5'd5 || WB_wr_en !== 1'b1) begin
            n_fail++; $display("FAIL b2b_load: wrdata=%h wraddr=%0d wr_en=%b want cafe0001 5 1", WB_wrdata, WB_wraddr, WB_wr_en);
        end
    endtask

    task automatic test_ack_idle();
        dmem.ack = 1'b1;
        @(negedge clk);
        n_checks++; if (dmem.req !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL ackidle_quiet: req=%b stall=%b want 0 0", dmem.req, stall);
        end
        @(posedge clk); #1;
        dmem.ack = 1'b0; dmem.rdata = 32'h1111_1111;
        MEM_sel_data = SEL_MEM; MEM_ALUres = 32'h400; MEM_wraddr = 5'd6; MEM_wr_en = 1'b1;
        @(negedge clk);
        n_checks++; if (stall !== 1'b1 || dmem.req !== 1'b1) begin
            n_fail++; $display("FAIL ackidle_wait: stall=%b req=%b want 1 1", stall, dmem.req);
        end
        @(posedge clk); #1;
        dmem.ack = 1'b1; dmem.rdata = 32'h2222_2222;
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ackidle_done: stall=%b want 0", stall); end
        @(posedge clk); #1;
        set_nop();
        n_checks++; if (WB_wrdata !== 32'h2222_2222 || WB_wr_en !== 1'b1) begin
            n_fail++; $display("FAIL ackidle_wb: wrdata=%h wr_en=%b want 22222222 1", WB_wrdata, WB_wr_en);
        end
    endtask

    task automatic test_timeout();
        int  stall_cycles = 0;
        bit  done = 1'b0;
        MEM_sel_data = SEL_MEM; MEM_ALUres = 32'h500; MEM_wraddr = 5'd7; MEM_wr_en = 1'b1; pc_MEM = 32'h3000;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (stall) stall_cycles++;
            else       done = 1'b1;
            if (!done) begin @(posedge clk); #1; end
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL to_bound: stall still %b after 40 cycles", stall); end
        n_checks++; if (stall_cycles != 16) begin n_fail++; $display("FAIL to_stall_count: got %0d want 16", stall_cycles); end
        n_checks++; if (dmem.req !== 1'b1 || bus_err !== 1'b0) begin
            n_fail++; $display("FAIL to_abort_cycle: req=%b bus_err=%b want 1 0", dmem.req, bus_err);
        end
        @(posedge clk); #1;
        set_nop();
        n_checks++; if (bus_err !== 1'b1 || WB_wr_en !== 1'b0 || pc_WB !== 32'h3000) begin
            n_fail++; $display("FAIL to_retire: bus_err=%b wr_en=%b pc=%h want 1 0 00003000", bus_err, WB_wr_en, pc_WB);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus_err !== 1'b1 || dmem.req !== 1'b0) begin
            n_fail++; $display("FAIL to_sticky: bus_err=%b req=%b want 1 0", bus_err, dmem.req);
        end
    endtask

    task automatic test_reset_wait();
        MEM_sel_data = SEL_ALU; MEM_ALUres = 32'hBEEF; MEM_wraddr = 5'd2; MEM_wr_en = 1'b1;
        pc_MEM = 32'h4000; MEM_inst = 32'h0000_0033;
        @(posedge clk); #1;
        MEM_sel_data = SEL_MEM; MEM_ALUres = 32'h600; MEM_wraddr = 5'd12; pc_MEM = 32'h4004;
        @(negedge clk);
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rw_stall: got %b want 1", stall); end
        @(posedge clk); #1;
        nrst = 1'b0;
        #1;
        n_checks++; if (dmem.req !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL rw_drop: req=%b stall=%b want 0 0", dmem.req, stall);
        end
        n_checks++; if ({WB_wrdata, WB_wraddr, WB_wr_en, pc_WB, WB_inst, align_err, bus_err} !== '0) begin
            n_fail++; $display("FAIL rw_clear: wrdata=%h wraddr=%0d wr_en=%b pc=%h inst=%h ae=%b be=%b want all 0",
                               WB_wrdata, WB_wraddr, WB_wr_en, pc_WB, WB_inst, align_err, bus_err);
        end
        set_nop();
        @(negedge clk); nrst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (dmem.req !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL rw_idle: req=%b stall=%b want 0 0", dmem.req, stall);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_wait_load();
        test_wait_store();
        test_jal();
        test_misaligned();
        test_back_to_back();
        test_ack_idle();
        test_timeout();
        test_reset_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EXE/MEM pipeline register outputs. Drives a handshaked data-memory port for loads and stores.
- Stalls upstream stages while an access is outstanding. Owns the MEM/WB pipeline register that feeds writeback.
- Handles misalignment and memory timeout without hanging the pipeline.

Parameters:
- TIMEOUT, 16, max cycles in WAIT without dmem_ack before abort (>=2).
- CNT_W, 5, width of timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock.
- nrst  in  1  reset.
- MEM_pc4  in  32  PC+4 of MEM instruction.
- MEM_ALUres  in  32  ALU result; memory byte address for ld/st.
- MEM_dataB  in  32  store data.
- MEM_wraddr  in  5  destination register.
- pc_MEM  in  32  PC of MEM instruction.
- MEM_inst  in  32  instruction word.
- MEM_data_wr  in  1  store.
- MEM_wr_en  in  1  register write enable.
- MEM_sel_data  in  2  writeback select: 00 ALU, 01 load, 10 pc4, 11 ALU.
- dmem_req  out  1  memory request, level.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word-aligned address.
- dmem_wdata  out  32  write data.
- dmem_rdata  in  32  read data, valid with dmem_ack.
- dmem_ack  in  1  access complete, may assert same cycle as req.
- stall  out  1  freeze PC, IF/ID, ID/EXE, EXE/MEM.
- WB_wrdata  out  32  writeback data.
- WB_wraddr  out  5  writeback register.
- WB_wr_en  out  1  writeback enable.
- pc_WB  out  32  PC of WB instruction.
- WB_inst  out  32  instruction in WB.
- align_err  out  1  one-cycle pulse, misaligned access retired.
- bus_err  out  1  sticky, timeout occurred.

Behaviour:
- Reset is nrst: asynchronous, active-low. Clock is clk.
- On reset: all WB_* outputs, pc_WB, align_err and bus_err are 0. State is IDLE and the counter is 0.
- Access type:
  - store = MEM_data_wr.
  - load = !MEM_data_wr & MEM_sel_data==01.
  - access = store|load.
  - misaligned = access & MEM_ALUres[1:0]!=0.
- Memory port outputs:
  - dmem_addr = {MEM_ALUres[31:2],2'b00}.
  - dmem_wdata = MEM_dataB.
  - dmem_we = store.
- States:
  - IDLE: dmem_req = access & !misaligned. If req & dmem_ack: complete, stay IDLE. If req & !ack: go WAIT, counter cleared.
  - WAIT: dmem_req=1. Counter increments each cycle. On ack: complete, go IDLE. If counter==TIMEOUT-1 & !ack: abort, set bus_err, go IDLE.
- stall (combinational) = access & !misaligned & !complete & !abort. It is high for exactly the cycles the request waits.
- MEM/WB register update:
  - If stall: WB_wr_en<=0 (bubble). Other WB_* fields don't-care but hold.
  - Else: load all WB_* fields from the MEM-stage inputs.
  - WB_wr_en <= MEM_wr_en & !misaligned & !abort.
  - WB_wrdata: sel 01 → dmem_rdata captured at the ack cycle; sel 10 → MEM_pc4; otherwise MEM_ALUres.
- Latency:
  - Non-memory or zero-wait access: 1 cycle, no stall.
  - N-cycle ack: N cycles of stall.
- Misaligned access: no request, no stall. align_err <= 1 for one cycle coincident with WB. The instruction retires with its write suppressed.
- Store never writes a register, even if MEM_wr_en=1 (decoder error tolerated).
- Inputs are held stable by upstream stall during WAIT. No re-issue occurs after completion because stall drops in the completion cycle.
- An ack in IDLE without a request is ignored.
- Reset mid-WAIT returns to IDLE immediately and drops dmem_req. A pending transaction is abandoned.

Optional Feature:
- Macro MEM_FWD_EN.
- When defined, adds outputs:
  - mem_fwd_valid (1) = MEM_wr_en & !load & !store.
  - mem_fwd_addr (5) = MEM_wraddr.
  - mem_fwd_data (32) = pc4 if sel 10, else ALUres.
- These are combinational and feed the EXE forwarding unit; loads are never forwarded from MEM.
- When undefined, these ports do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - SEL_ALU=2'b00, SEL_MEM=2'b01, SEL_PC4=2'b10.
  - State encodings ST_IDLE, ST_WAIT.
  - Widths DATA_W=32, REG_W=5.
- One sub-module, mem_wb_reg, is natural: the plain async-reset MEM/WB register with a bubble input. The FSM, counter and mux stay in the top.

Test Plan:
- Zero-wait load: ALUres=0x100, sel=01, wr_en=1, wraddr=8; ack same cycle with rdata=0xDEADBEEF → no stall; next cycle WB_wrdata=0xDEADBEEF, WB_wraddr=8, WB_wr_en=1.
- 3-cycle store: data_wr=1, dataB=0x12345678, ALUres=0x204; ack on 3rd cycle → stall high 2 cycles; dmem_we=1, dmem_addr=0x204; WB_wr_en=0 at retire.
- Misaligned load: ALUres=0x102, sel=01 → dmem_req=0, stall=0; next cycle align_err=1, WB_wr_en=0.
- Timeout (TIMEOUT=16): load, ack never asserted → stall for 16 cycles then drops; bus_err=1 and stays 1; WB_wr_en=0.
- jal writeback: sel=10, pc4=0x40, wraddr=31 → WB_wrdata=0x40, WB_wr_en=1, no request. Under MEM_FWD_EN: mem_fwd_valid=1, mem_fwd_data=0x40.
- Reset during WAIT: nrst low while awaiting ack → dmem_req, stall and all WB_* are 0 immediately; after release, state is IDLE.
